// File: rtl/cartesian_to_polar.sv
// Sign-magnitude Cartesian (x, y) to packed polar {theta_code, r} converter.
// A 9-step restoring square root produces r. The first six of those steps
// also test one 15-degree sector boundary each, giving the theta code.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// SQ    | form ax*ax + ay*ay, clear root and sector count
// ITER  | 9 root steps (bit 8..0), sector tests on bits 8..3
// DONE  | publish result; start here begins the next conversion
module cartesian_to_polar #(
  parameter int SAT_R = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  x_value,
  input  logic [8:0]  y_value,
  output logic        busy,
  output logic        done,
  output logic [11:0] r_theta,
  output logic        r_saturated,
  output logic        below_axis
);

  typedef enum logic [1:0] {IDLE, SQ, ITER, DONE} state_t;

  localparam logic [7:0] SAT_R8 = 8'(SAT_R);

  state_t state, state_nxt;
  logic   capture;

  logic [7:0]  ax, ay;
  logic        xneg, yneg;
  logic [16:0] sum;
  logic [8:0]  res;
  logic [3:0]  bit_idx;
  logic [3:0]  k;

  logic [8:0]  trial;
  logic [17:0] trial_sq;
  logic [10:0] thr;
  logic        sector_en;
  logic [19:0] ay_scaled;
  logic [19:0] ax_thr;
  logic        boundary_hit;
  logic [3:0]  theta_code;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and input-capture strobe
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = SQ;
        end
      end
      SQ:   state_nxt = ITER;
      ITER: if (bit_idx == 4'd0) state_nxt = DONE;
      DONE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = SQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SQ) || (state == ITER);

  // Root trial value and sector boundary for the current step
  always_comb begin
    trial     = res | (9'd1 << bit_idx);
    trial_sq  = {9'd0, trial} * {9'd0, trial};
    thr       = 11'd0;
    sector_en = 1'b0;
    case (bit_idx)
      4'd8: begin thr = 11'd34;   sector_en = 1'b1; end
      4'd7: begin thr = 11'd106;  sector_en = 1'b1; end
      4'd6: begin thr = 11'd196;  sector_en = 1'b1; end
      4'd5: begin thr = 11'd334;  sector_en = 1'b1; end
      4'd4: begin thr = 11'd618;  sector_en = 1'b1; end
      4'd3: begin thr = 11'd1945; sector_en = 1'b1; end
      default: begin thr = 11'd0; sector_en = 1'b0; end
    endcase
    ay_scaled = {4'd0, ay, 8'd0};
    ax_thr    = {12'd0, ax} * {9'd0, thr};
    // ay == 0 keeps the origin at 0 deg instead of counting every boundary
    boundary_hit = sector_en && (ay != 8'd0) && (ay_scaled >= ax_thr);
    theta_code   = xneg ? (4'd12 - k) : k;
  end

  // Operand capture, root/sector iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ax          <= 8'd0;
      ay          <= 8'd0;
      xneg        <= 1'b0;
      yneg        <= 1'b0;
      sum         <= 17'd0;
      res         <= 9'd0;
      bit_idx     <= 4'd0;
      k           <= 4'd0;
      done        <= 1'b0;
      r_theta     <= 12'd0;
      r_saturated <= 1'b0;
      below_axis  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        ax   <= x_value[7:0];
        ay   <= y_value[7:0];
        xneg <= x_value[8] && (x_value[7:0] != 8'd0);
        yneg <= y_value[8];
      end
      case (state)
        SQ: begin
          sum     <= ({9'd0, ax} * {9'd0, ax}) + ({9'd0, ay} * {9'd0, ay});
          res     <= 9'd0;
          k       <= 4'd0;
          bit_idx <= 4'd8;
        end
        ITER: begin
          if (trial_sq <= {1'b0, sum}) res <= trial;
          if (boundary_hit) k <= k + 4'd1;
          bit_idx <= bit_idx - 4'd1;
        end
        DONE: begin
          done        <= 1'b1;
          r_theta     <= {theta_code, (res > {1'b0, SAT_R8}) ? SAT_R8 : res[7:0]};
          r_saturated <= (res > {1'b0, SAT_R8});
          below_axis  <= yneg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cartesian_to_polar.sv
// Self-checking bench for cartesian_to_polar: scoreboard of expected results,
// latency/throughput timing, busy masking of start, and reset abort.
module tb_cartesian_to_polar;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  x_value;
  logic [8:0]  y_value;
  logic        busy;
  logic        done;
  logic [11:0] r_theta;
  logic        r_saturated;
  logic        below_axis;

  typedef struct packed {
    logic [11:0] rt;
    logic        sat;
    logic        below;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cartesian_to_polar #(.SAT_R(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .x_value     (x_value),
    .y_value     (y_value),
    .busy        (busy),
    .done        (done),
    .r_theta     (r_theta),
    .r_saturated (r_saturated),
    .below_axis  (below_axis)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: integer floor sqrt by linear search, sector by boundary count.
  function automatic exp_t model(input logic [8:0] x, input logic [8:0] y);
    int ax, ay, s, r, k;
    int thr [6] = '{34, 106, 196, 334, 618, 1945};
    logic [3:0] th;
    logic [7:0] rr;
    exp_t e;
    ax = int'(x[7:0]);
    ay = int'(y[7:0]);
    s  = ax * ax + ay * ay;
    r  = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    k = 0;
    for (int j = 0; j < 6; j++)
      if (ay != 0 && ay * 256 >= ax * thr[j]) k++;
    th = (x[8] && ax != 0) ? 4'(12 - k) : 4'(k);
    rr = (r > 255) ? 8'hFF : 8'(r);
    e.rt    = {th, rr};
    e.sat   = (r > 255);
    e.below = y[8];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; returns just after the sampling edge.
  task automatic pulse_start(input logic [8:0] x, input logic [8:0] y);
    x_value = x;
    y_value = y;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Waits (bounded) for done; counts cycles and busy samples on the way.
  task automatic wait_done(output int cycles, output int busy_cnt, output bit ok);
    cycles   = 0;
    busy_cnt = busy ? 1 : 0;
    ok       = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        cycles = i;
        ok     = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; x_value = 9'd0; y_value = 9'd0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({busy, done, r_theta, r_saturated, below_axis} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got busy=%b done=%b rt=%h sat=%b below=%b, want all 0",
                 i, busy, done, r_theta, r_saturated, below_axis);
      end
    end
  endtask

  task automatic test_single();
    int cyc, bcnt; bit ok; exp_t e; exp_t got;
    exp_q.push_back('{rt: 12'h3C7, sat: 1'b0, below: 1'b0});
    pulse_start(9'd141, 9'd141);
    wait_done(cyc, bcnt, ok);
    n_checks++;
    if (!ok || cyc != 11) begin
      n_fail++;
      $display("FAIL single_latency: got %0d (seen=%0d), want 11", cyc, ok);
    end
    n_checks++;
    if (bcnt != 10) begin
      n_fail++;
      $display("FAIL single_busy_cycles: got %0d, want 10", bcnt);
    end
    e = exp_q.pop_front();
    got = '{rt: r_theta, sat: r_saturated, below: below_axis};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL single_result: got rt=%h sat=%b below=%b, want rt=%h sat=%b below=%b",
               got.rt, got.sat, got.below, e.rt, e.sat, e.below);
    end
    step();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_pulse: done=%b one cycle later, want 0", done);
    end
    repeat (3) step();
    n_checks++;
    if (r_theta !== e.rt) begin
      n_fail++;
      $display("FAIL single_hold: got rt=%h, want %h", r_theta, e.rt);
    end
  endtask

  task automatic test_vectors();
    logic [8:0] xs [$];
    logic [8:0] ys [$];
    exp_t       fixed [$];
    int cyc, bcnt; bit ok; exp_t e; exp_t got;
    xs.push_back(9'h100 | 9'd246); ys.push_back(9'd65);  fixed.push_back('{rt: 12'hBFE, sat: 1'b0, below: 1'b0});
    xs.push_back(9'd255);          ys.push_back(9'd255); fixed.push_back('{rt: 12'h3FF, sat: 1'b1, below: 1'b0});
    xs.push_back(9'd0);            ys.push_back(9'd0);   fixed.push_back('{rt: 12'h000, sat: 1'b0, below: 1'b0});
    xs.push_back(9'h100);          ys.push_back(9'd100); fixed.push_back('{rt: 12'h664, sat: 1'b0, below: 1'b0});
    for (int i = 0; i < 10; i++) begin
      logic [8:0] rx, ry;
      rx = 9'($urandom_range(0, 511));
      ry = 9'($urandom_range(0, 511));
      xs.push_back(rx); ys.push_back(ry); fixed.push_back(model(rx, ry));
    end
    xs.push_back(9'h100 | 9'd90); ys.push_back(9'd0);
    fixed.push_back(model(9'h100 | 9'd90, 9'd0));
    for (int i = 0; i < xs.size(); i++) begin
      exp_q.push_back(fixed[i]);
      pulse_start(xs[i], ys[i]);
      wait_done(cyc, bcnt, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL vec%0d_timeout: no done within 20 cycles, want done", i);
        e = exp_q.pop_front();
      end else begin
        e = exp_q.pop_front();
        got = '{rt: r_theta, sat: r_saturated, below: below_axis};
        if (got !== e) begin
          n_fail++;
          $display("FAIL vec%0d x=%h y=%h: got rt=%h sat=%b below=%b, want rt=%h sat=%b below=%b",
                   i, xs[i], ys[i], got.rt, got.sat, got.below, e.rt, e.sat, e.below);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt; bit ok; exp_t e; exp_t got;
    x_value = 9'd100;
    y_value = 9'h100 | 9'd100;
    for (int i = 0; i < 4; i++) exp_q.push_back('{rt: 12'h38D, sat: 1'b0, below: 1'b1});
    start = 1'b1;
    step();
    for (int n = 0; n < 4; n++) begin
      wait_done(cyc, bcnt, ok);
      if (n == 2) start = 1'b0;
      n_checks++;
      if (!ok || cyc != 11) begin
        n_fail++;
        $display("FAIL b2b_interval%0d: got %0d (seen=%0d), want 11", n, cyc, ok);
      end
      e = exp_q.pop_front();
      got = '{rt: r_theta, sat: r_saturated, below: below_axis};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL b2b_result%0d: got rt=%h sat=%b below=%b, want rt=%h sat=%b below=%b",
                 n, got.rt, got.sat, got.below, e.rt, e.sat, e.below);
      end
    end
    repeat (3) step();
  endtask

  task automatic test_start_while_busy();
    int first, cnt; exp_t e; exp_t got;
    first = 0; cnt = 0;
    exp_q.push_back('{rt: 12'h432, sat: 1'b0, below: 1'b0});
    pulse_start(9'd30, 9'd40);
    for (int i = 1; i <= 30; i++) begin
      step();
      if (done) begin
        cnt++;
        if (first == 0) begin
          first = i;
          e = exp_q.pop_front();
          got = '{rt: r_theta, sat: r_saturated, below: below_axis};
          n_checks++;
          if (got !== e) begin
            n_fail++;
            $display("FAIL busy_ignore_result: got rt=%h sat=%b below=%b, want rt=%h sat=%b below=%b",
                     got.rt, got.sat, got.below, e.rt, e.sat, e.below);
          end
        end
      end
      if (i <= 7) begin
        start   = i[0];
        x_value = 9'($urandom_range(0, 511));
        y_value = 9'($urandom_range(0, 511));
      end else begin
        start = 1'b0;
      end
    end
    n_checks++;
    if (first != 11 || cnt != 1) begin
      n_fail++;
      $display("FAIL busy_ignore_done: got first=%0d count=%0d, want first=11 count=1", first, cnt);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, bcnt, cnt; bit ok; exp_t e; exp_t got;
    pulse_start(9'd60, 9'd80);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({busy, done, r_theta, r_saturated, below_axis} !== 16'h0) begin
      n_fail++;
      $display("FAIL abort_clear: got busy=%b done=%b rt=%h sat=%b below=%b, want all 0",
               busy, done, r_theta, r_saturated, below_axis);
    end
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || busy) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d busy/done cycles, want 0", cnt);
    end
    exp_q.push_back('{rt: 12'h464, sat: 1'b0, below: 1'b0});
    pulse_start(9'd60, 9'd80);
    wait_done(cyc, bcnt, ok);
    n_checks++;
    if (!ok || cyc != 11) begin
      n_fail++;
      $display("FAIL abort_restart_latency: got %0d (seen=%0d), want 11", cyc, ok);
    end
    e = exp_q.pop_front();
    got = '{rt: r_theta, sat: r_saturated, below: below_axis};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL abort_restart_result: got rt=%h sat=%b below=%b, want rt=%h sat=%b below=%b",
               got.rt, got.sat, got.below, e.rt, e.sat, e.below);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_vectors();
    test_back_to_back();
    test_start_while_busy();
    test_reset_abort();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cartesian_to_polar.md
Name: cartesian_to_polar

Overview:
- Sequential converter from sign-magnitude Cartesian (x, y) to packed polar r_theta: r in [7:0], theta code in [11:8] (units of 15 deg, 0..12 spanning 0..180 deg).
- Inverse of the combinational polar-to-cartesian block. Consumes its 9-bit {sign, 8-bit magnitude} format.
- Feeds r_theta back into the display/tracking path.
- Uses a start/done handshake and a fixed-latency iterative square root with a parallel sector search.

Parameters:
- SAT_R, 255, maximum reported r; larger magnitudes clamp to this value.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE or DONE
- x_value  input  9  bit 8 = sign (1 = negative), [7:0] = magnitude
- y_value  input  9  same format as x_value
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when r_theta is updated
- r_theta  output  12  [11:8] theta code, [7:0] r; holds until the next done
- r_saturated  output  1  r was clamped to SAT_R; valid with and held like r_theta
- below_axis  output  1  y sign bit was set (input mirrored); valid with and held like r_theta

Behaviour:
- Reset (synchronous):
  - State returns to IDLE.
  - busy, done, r_theta, r_saturated and below_axis all clear to 0.
  - Reset wins over every other event and aborts any conversion in flight.
- States:
  - IDLE: wait for start. On start, capture ax = x[7:0], ay = y[7:0], xneg = x[8] and (ax != 0), yneg = y[8]. Go to SQ.
  - SQ, 1 cycle: sum = ax*ax + ay*ay as 17 bits unsigned (maximum 130050, so no overflow). Clear res and k. Go to ITER.
  - ITER, 9 cycles, i = 8 down to 0:
    - Restoring square root. trial = res | (1<<i); if trial*trial <= sum then res = trial.
    - During the first 6 iterations, also evaluate one sector boundary per cycle, in the order T = 34, 106, 196, 334, 618, 1945 (tan of 7.5/22.5/37.5/52.5/67.5/82.5 deg scaled by 256).
    - Boundary test: if ay*256 >= ax*T then k = k + 1. Use widths of at least 20 bits.
    - After the 9th iteration go to DONE.
  - DONE, 1 cycle:
    - done = 1, busy = 0.
    - r_theta[7:0] = min(res, SAT_R).
    - r_saturated = (res > SAT_R).
    - r_theta[11:8] = xneg ? 12 - k : k.
    - below_axis = yneg.
    - If start is high in this cycle, capture new inputs and go to SQ (back-to-back operation). Otherwise go to IDLE.
- busy is 1 in SQ and ITER, and 0 in IDLE and DONE.
- Latency: start sampled at edge N, done high in the cycle after edge N+11. Throughput is one conversion per 11 clocks.
- start is ignored while busy is 1. Captured inputs are never re-sampled mid-conversion.
- r is the floor of the square root. Theta is the nearest 15 deg sector. A value exactly on a boundary rounds to the higher sector.
- Edge cases:
  - Negative zero on x is treated as positive.
  - x = y = 0 gives r_theta = 0x000.
  - ax = 0 with ay > 0 gives k = 6 (90 deg).
- Negative y: the angle is computed from |y| (the mirror image in the upper half-plane) and below_axis is flagged. Downstream logic decides whether to discard the result.
- Only codes 0..12 are produced; 13..15 never appear.

Test Plan:
- Reset, then idle for 5 clocks -> all outputs 0, done never asserted.
- x = +141, y = +141, start pulse -> busy for 10 cycles; done exactly 11 clocks after the start edge; r_theta = 0x3C7 (r = 199, 45 deg); r_saturated = 0, below_axis = 0.
- x = -246, y = +65 (r = 255, 165 deg as generated by the forward block) -> r_theta = 0xBFE.
- x = +255, y = +255 -> r_theta = 0x3FF, r_saturated = 1. Then x = 0, y = 0 -> 0x000. Then x = -0, y = +100 -> 0x664.
- x = +100, y = -100 -> r_theta = 0x38D, below_axis = 1. Hold start high continuously -> done pulses every 11 clocks; start pulses while busy produce no extra done.
- Assert reset 4 cycles into a conversion -> next cycle busy = 0 and outputs cleared, and no done follows. A new start after reset converts correctly.
